cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
Two-to-one memory-port arbiter between the instruction cache and the data cache. Each cache issues line refill and evict requests. The arbiter grants one requester, forwards its request to the single memory port, and routes the memory response back to the granted requester. It keeps one transaction in flight at a time. It sits between the two cache controllers' memreq/memresp interfaces and the memory.

Parameters:
p_data_nbits, 128, line data width in bits (one 16-byte cache line).
p_addr_nbits, 32, address width.
p_round_robin, 1, 1 = round-robin priority; 0 = fixed priority with port 0 highest.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req{0,1}_val  input  1  cache N memory request valid (0 = icache, 1 = dcache)
req{0,1}_rdy  output  1  cache N request accepted this cycle when high together with val
req{0,1}_type  input  3  request type: READ=0, WRITE=1 (codebase mem-msg encoding)
req{0,1}_addr  input  p_addr_nbits  line address
req{0,1}_data  input  p_data_nbits  write data
resp{0,1}_val  output  1  response valid to cache N
resp{0,1}_rdy  input  1  cache N accepts the response
resp{0,1}_type  output  3  response type, copied from memory
resp{0,1}_data  output  p_data_nbits  response data, copied from memory
memreq_val  output  1  memory request valid
memreq_rdy  input  1  memory accepts the request
memreq_type  output  3  latched request type
memreq_addr  output  p_addr_nbits  latched request address
memreq_data  output  p_data_nbits  latched request data
memresp_val  input  1  memory response valid
memresp_rdy  output  1  arbiter accepts the memory response
memresp_type  input  3  memory response type
memresp_data  input  p_data_nbits  memory response data
owner  output  1  index of the currently granted requester
busy  output  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, MREQ, MWAIT, RESP. All state updates happen on the posedge of clk.
- Reset: state = IDLE; last_grant = 1 (so port 0 wins the first tie); owner = 0; request/response latches are cleared to 0.
- While reset is high, every val/rdy output is 0.
- Reset mid-transaction: the transaction is abandoned and no response is delivered. The memory port is not drained.
- Winner in IDLE:
  - Only one reqN_val high: that port wins.
  - Both high, p_round_robin=1: the port != last_grant wins.
  - Both high, p_round_robin=0: port 0 wins.
- IDLE: reqN_rdy = 1 only for the winner; the loser sees rdy = 0. rdy may depend on val; val must never depend on rdy. On the accepting handshake:
  - latch type, addr and data;
  - owner <= N; last_grant <= N;
  - next state MREQ.
- MREQ:
  - memreq_val = 1, driving the latched fields. These stay stable until memreq_rdy.
  - On memreq_rdy: go to MWAIT.
  - Both reqN_rdy = 0.
- MWAIT:
  - memresp_rdy = 1.
  - On memresp_val: latch memresp_type and memresp_data, then go to RESP.
- RESP:
  - resp[owner]_val = 1 with the latched type and data. The other resp_val = 0.
  - Hold until resp[owner]_rdy, then go to IDLE.
- memresp_rdy = 0 outside MWAIT. A memresp_val arriving outside MWAIT is not consumed (it stalls at the memory).
- Latency, no backpressure: request accepted in cycle T → memreq_val in T+1 → memresp accepted at the earliest in T+2 → resp_val in T+3 → next request accepted at the earliest in T+4.
- resp outputs are fully registered. There is no combinational path from the memresp inputs to the resp outputs, nor from the req inputs to the memreq outputs.
- A request held pending while the arbiter is busy stays pending. The requester keeps val high and the request is granted in a later IDLE.
- Starvation bound with round-robin: a pending requester is granted within one other transaction.
- Type fields pass through unmodified. The arbiter does not interpret READ vs WRITE beyond forwarding.

Test Plan:
1. Reset, then req0 READ, addr 0x0000_1000: cycle T+1 memreq_val=1, addr 0x1000, type 0. Memory returns data 0xDEAD…BEEF in T+2 → resp0_val=1 in T+3 with that data; resp1_val stays 0.
2. req0 and req1 both valid in the same cycle after reset: port 0 served first (owner=0). Port 1 granted in the first IDLE after resp0 completes. With p_round_robin=1, the next tie goes to port 0 again (alternation 0,1,0,1 over 4 tied requests).
3. p_round_robin=0, both ports continuously valid: port 0 is granted every transaction and port 1 is never granted.
4. Hold memreq_rdy=0 for 5 cycles: memreq_val, addr and data stay constant for all 5 cycles, no state change, both reqN_rdy=0.
5. Hold resp1_rdy=0 for 3 cycles after a dcache WRITE: resp1_val and resp1_type=1 held stable; memresp_rdy=0. A new req0 waits with req0_rdy=0 until the response handshake completes.
6. Assert reset while in MWAIT: the next cycle shows state IDLE, busy=0, no resp_val. A subsequent req1 is granted normally with last_grant reset to 1.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: two-to-one icache/dcache arbiter onto one memory port, one transaction in flight
module cache_mem_arbiter #(
    parameter int p_data_nbits  = 128,
    parameter int p_addr_nbits  = 32,
    parameter int p_round_robin = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [2:0]              req0_type,
    input  logic [p_addr_nbits-1:0] req0_addr,
    input  logic [p_data_nbits-1:0] req0_data,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [2:0]              req1_type,
    input  logic [p_addr_nbits-1:0] req1_addr,
    input  logic [p_data_nbits-1:0] req1_data,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [2:0]              resp0_type,
    output logic [p_data_nbits-1:0] resp0_data,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [2:0]              resp1_type,
    output logic [p_data_nbits-1:0] resp1_data,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [2:0]              memreq_type,
    output logic [p_addr_nbits-1:0] memreq_addr,
    output logic [p_data_nbits-1:0] memreq_data,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [2:0]              memresp_type,
    input  logic [p_data_nbits-1:0] memresp_data,
    output logic                    owner,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

    state_t                  state, next_state;
    logic                    last_grant, win, any_req, resp_hs;
    logic [2:0]              q_type, r_type;
    logic [p_addr_nbits-1:0] q_addr;
    logic [p_data_nbits-1:0] q_data, r_data;

    // arbitration: lone requester wins; on a tie round-robin skips last_grant, fixed mode picks port 0
    always_comb begin
        any_req = req0_val | req1_val;
        win     = (req0_val && req1_val) ? ((p_round_robin != 0) ? ~last_grant : 1'b0) : ~req0_val;
        resp_hs = owner ? resp1_rdy : resp0_rdy;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : next_state;
    end

    // next-state: the winner is always ready in IDLE, so any valid request is accepted
    always_comb begin
        next_state = (state == IDLE)  ? (any_req ? MREQ : IDLE) :
                     (state == MREQ)  ? (memreq_rdy ? MWAIT : MREQ) :
                     (state == MWAIT) ? (memresp_val ? RESP : MWAIT) :
                                        (resp_hs ? IDLE : RESP);
    end

    // outputs: handshake signals are forced low during reset, payloads come straight from latches
    always_comb begin
        req0_rdy    = !reset && state == IDLE && req0_val && !win;
        req1_rdy    = !reset && state == IDLE && req1_val && win;
        memreq_val  = !reset && state == MREQ;
        memresp_rdy = !reset && state == MWAIT;
        resp0_val   = !reset && state == RESP && !owner;
        resp1_val   = !reset && state == RESP && owner;
        busy        = state != IDLE;
        memreq_type = q_type;
        memreq_addr = q_addr;
        memreq_data = q_data;
        resp0_type  = r_type;
        resp0_data  = r_data;
        resp1_type  = r_type;
        resp1_data  = r_data;
    end

    // request and response latches plus grant bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            q_type     <= '0;
            q_addr     <= '0;
            q_data     <= '0;
            r_type     <= '0;
            r_data     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && any_req) begin
                q_type     <= win ? req1_type : req0_type;
                q_addr     <= win ? req1_addr : req0_addr;
                q_data     <= win ? req1_data : req0_data;
                owner      <= win;
                last_grant <= win;
            end
            if (state == MWAIT && memresp_val) begin
                r_type <= memresp_type;
                r_data <= memresp_data;
            end
        end
    end

endmodule
